// File: rtl/watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : watch_pkg
//  Purpose  : Shared definitions for the stopwatch preset editor: editor
//             state encoding, digit count, per-digit wrap limits and the
//             bit positions of each BCD field inside the 24-bit preset.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package watch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam int         DIGITS     = 6;
    localparam int         DIGIT_W    = 4;
    localparam logic [2:0] CURSOR_TOP = 3'd5;

    // Highest legal value of each digit, digit 5 (min tens) down to digit 0.
    localparam logic [3:0] LIMIT_MIN_TENS  = 4'd5;
    localparam logic [3:0] LIMIT_MIN_UNITS = 4'd9;
    localparam logic [3:0] LIMIT_SEC_TENS  = 4'd5;
    localparam logic [3:0] LIMIT_SEC_UNITS = 4'd9;
    localparam logic [3:0] LIMIT_TENTHS    = 4'd9;
    localparam logic [3:0] LIMIT_HUNDREDS  = 4'd9;

    // Least-significant bit of each field within the preset word.
    localparam int LSB_MIN_TENS  = 20;
    localparam int LSB_MIN_UNITS = 16;
    localparam int LSB_SEC_TENS  = 12;
    localparam int LSB_SEC_UNITS = 8;
    localparam int LSB_TENTHS    = 4;
    localparam int LSB_HUNDREDS  = 0;

    function automatic logic [3:0] digit_limit(input int idx);
        case (idx)
            5:       return LIMIT_MIN_TENS;
            4:       return LIMIT_MIN_UNITS;
            3:       return LIMIT_SEC_TENS;
            2:       return LIMIT_SEC_UNITS;
            1:       return LIMIT_TENTHS;
            default: return LIMIT_HUNDREDS;
        endcase
    endfunction

    function automatic int digit_lsb(input int idx);
        case (idx)
            5:       return LSB_MIN_TENS;
            4:       return LSB_MIN_UNITS;
            3:       return LSB_SEC_TENS;
            2:       return LSB_SEC_UNITS;
            1:       return LSB_TENTHS;
            default: return LSB_HUNDREDS;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce
//  Purpose  : Conditions one raw push-button: 2-FF synchronizer, counting
//             debouncer and rising-edge detector producing a one-cycle press.
//  Ports    : clk   - clock
//             rst   - asynchronous active-high reset
//             raw   - raw button level, asynchronous, 1 = pressed
//             press - one-cycle pulse on each debounced press
//  Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_q;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_q <= r_level;
            // The count only survives while the synced input disagrees with
            // the debounced level; any agreeing sample restarts the wait.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_W'(DEBOUNCE_CYCLES)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/preset_entry.sv
`default_nettype none
// ============================================================================
//  Module   : preset_entry
//  Purpose  : Keypad preset editor. Three debounced keys walk a cursor over
//             six BCD digits, increment the selected digit within its legal
//             range, and commit the value with a one-cycle load strobe.
//  Ports    : clk_50Mhz   - clock
//             rst         - asynchronous active-high reset
//             key_sel     - raw select key (cursor / enter edit)
//             key_inc     - raw increment key
//             key_ok      - raw confirm key
//             preset      - 24-bit BCD preset mm:ss.hh
//             load        - one-cycle commit strobe
//             edit_active - high while editing
//             cursor      - digit under edit, 5 = [23:20] .. 0 = [3:0]
//  Revision : 1.0 - initial release
// ============================================================================
module preset_entry
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk_50Mhz,
    input  logic        rst,
    input  logic        key_sel,
    input  logic        key_inc,
    input  logic        key_ok,
    output logic [23:0] preset,
    output logic        load,
    output logic        edit_active,
    output logic [2:0]  cursor
);

    logic w_sel_p;
    logic w_inc_p;
    logic w_ok_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk   (clk_50Mhz),
        .rst   (rst),
        .raw   (key_sel),
        .press (w_sel_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk_50Mhz),
        .rst   (rst),
        .raw   (key_inc),
        .press (w_inc_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
        .clk   (clk_50Mhz),
        .rst   (rst),
        .raw   (key_ok),
        .press (w_ok_p)
    );

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cursor;
    logic [2:0]  w_cursor_nxt;
    logic [23:0] r_preset;
    logic [23:0] w_preset_nxt;

    always_ff @(posedge clk_50Mhz or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cursor <= CURSOR_TOP;
            r_preset <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cursor <= w_cursor_nxt;
            r_preset <= w_preset_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        w_preset_nxt = r_preset;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_p) begin
                    w_state_nxt  = ST_EDIT;
                    w_cursor_nxt = CURSOR_TOP;
                end
            end
            ST_EDIT: begin
                // ok outranks sel outranks inc; losers are simply dropped.
                if (w_ok_p) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_sel_p) begin
                    w_cursor_nxt = (r_cursor == 3'd0) ? CURSOR_TOP : r_cursor - 3'd1;
                end else if (w_inc_p) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_cursor == 3'(i)) begin
                            // >= keeps a digit legal even if it were ever out of range.
                            if (r_preset[digit_lsb(i) +: DIGIT_W] >= digit_limit(i)) begin
                                w_preset_nxt[digit_lsb(i) +: DIGIT_W] = 4'd0;
                            end else begin
                                w_preset_nxt[digit_lsb(i) +: DIGIT_W] =
                                    r_preset[digit_lsb(i) +: DIGIT_W] + 4'd1;
                            end
                        end
                    end
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign preset      = r_preset;
    assign cursor      = r_cursor;
    assign load        = (r_state == ST_COMMIT);
    assign edit_active = (r_state == ST_EDIT);

endmodule
`default_nettype wire
